// File: rtl/pipe_pkg.sv
// Shared MIPS32 pipeline definitions: packed ID/EX control-word layout,
// NOP constant and the bubble-insertion FSM state encoding.
package pipe_pkg;

  localparam int CTRL_W = 15;

  // Field widths inside the packed control word
  localparam int JUMP_W       = 2;
  localparam int MEM_TO_REG_W = 2;
  localparam int REG_DST_W    = 2;
  localparam int ALU_OP_W     = 4;

  // Field LSB offsets (word is {jump, branch, mem_read, mem_to_reg, mem_write,
  // alu_src, reg_write, reg_dst, alu_op}, MSB first)
  localparam int ALU_OP_LSB     = 0;
  localparam int REG_DST_LSB    = 4;
  localparam int REG_WRITE_BIT  = 6;
  localparam int ALU_SRC_BIT    = 7;
  localparam int MEM_WRITE_BIT  = 8;
  localparam int MEM_TO_REG_LSB = 9;
  localparam int MEM_READ_BIT   = 11;
  localparam int BRANCH_BIT     = 12;
  localparam int JUMP_LSB       = 13;

  localparam logic [CTRL_W-1:0] NOP = '0;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  typedef struct packed {
    logic [JUMP_W-1:0]       jump;
    logic                    branch;
    logic                    mem_read;
    logic [MEM_TO_REG_W-1:0] mem_to_reg;
    logic                    mem_write;
    logic                    alu_src;
    logic                    reg_write;
    logic [REG_DST_W-1:0]    reg_dst;
    logic [ALU_OP_W-1:0]     alu_op;
  } ctrl_t;

  function automatic logic [CTRL_W-1:0] pack_ctrl(input ctrl_t c);
    return c;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc and sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {W{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/ctrl_bubble_pipe.sv
// ID/EX control-word register that inserts a programmable run of NOP bubbles
// on a stall request, throttling IF/ID while bubbles are in flight.
module ctrl_bubble_pipe
  import pipe_pkg::*;
#(
  parameter int CTRL_W = pipe_pkg::CTRL_W,
  parameter int CNT_W  = 3,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              valid_in,
  input  logic              stall_req,
  input  logic [CNT_W-1:0]  stall_len,
  input  logic              flush,
  input  logic              hold,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              valid_out,
  output logic              upstream_hold,
  output logic [STAT_W-1:0] bubble_cnt
);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  remaining_reg, remaining_next;
  logic [CTRL_W-1:0] ctrl_reg, ctrl_next;
  logic              valid_reg, valid_next;
  logic              bubble_inc;
  logic              stall_start;

  assign stall_start = stall_req && (stall_len != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= RUN;
      remaining_reg <= '0;
      ctrl_reg      <= '0;
      valid_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      ctrl_reg      <= ctrl_next;
      valid_reg     <= valid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    ctrl_next      = ctrl_reg;
    valid_next     = valid_reg;
    bubble_inc     = 1'b0;

    if (flush) begin
      // Flush zeros are a kill, not a bubble, so they are not counted.
      state_next     = RUN;
      remaining_next = '0;
      ctrl_next      = '0;
      valid_next     = 1'b0;
    end else if (!hold) begin
      unique case (state_reg)
        RUN: begin
          if (stall_start) begin
            ctrl_next  = '0;
            valid_next = 1'b0;
            bubble_inc = 1'b1;
            if (stall_len > CNT_W'(1)) begin
              remaining_next = stall_len - CNT_W'(1);
              state_next     = STALL;
            end
          end else begin
            ctrl_next  = ctrl_in;
            valid_next = valid_in;
          end
        end
        STALL: begin
          // stall_req is deliberately ignored here: no re-arm or extension.
          ctrl_next      = '0;
          valid_next     = 1'b0;
          bubble_inc     = 1'b1;
          remaining_next = remaining_reg - CNT_W'(1);
          if (remaining_reg == CNT_W'(1)) begin
            state_next = RUN;
          end
        end
        default: begin
          state_next     = RUN;
          remaining_next = '0;
        end
      endcase
    end
  end

  // A flush releases the front end in the same cycle, aborting any stall.
  assign upstream_hold = hold ||
                         (!flush && ((state_reg == STALL) ||
                                     ((state_reg == RUN) && stall_start)));

  sat_counter #(
    .W(STAT_W)
  ) u_bubble_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (bubble_inc),
    .count(bubble_cnt)
  );

  assign ctrl_out  = ctrl_reg;
  assign valid_out = valid_reg;

endmodule

// File: tb/tb_ctrl_bubble_pipe.sv
// Directed scoreboard bench for ctrl_bubble_pipe, with a narrow-counter
// instance sharing the stimulus to exercise bubble_cnt saturation.
module tb_ctrl_bubble_pipe;

  logic        clk;
  logic        rst;
  logic [14:0] ctrl_in;
  logic        valid_in;
  logic        stall_req;
  logic [2:0]  stall_len;
  logic        flush;
  logic        hold;

  logic [14:0] ctrl_out, ctrl_out_s;
  logic        valid_out, valid_out_s;
  logic        upstream_hold, upstream_hold_s;
  logic [15:0] bubble_cnt;
  logic [3:0]  bubble_cnt_s;

  int checks = 0;
  int errors = 0;
  int bubbles = 0;

  typedef struct {
    logic [14:0] ctrl;
    logic        valid;
    int          cnt;
    int          sat;
  } exp_t;
  exp_t exp_q[$];

  ctrl_bubble_pipe #(.CTRL_W(15), .CNT_W(3), .STAT_W(16)) dut (
    .clk(clk), .rst(rst), .ctrl_in(ctrl_in), .valid_in(valid_in),
    .stall_req(stall_req), .stall_len(stall_len), .flush(flush), .hold(hold),
    .ctrl_out(ctrl_out), .valid_out(valid_out),
    .upstream_hold(upstream_hold), .bubble_cnt(bubble_cnt)
  );

  ctrl_bubble_pipe #(.CTRL_W(15), .CNT_W(3), .STAT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .ctrl_in(ctrl_in), .valid_in(valid_in),
    .stall_req(stall_req), .stall_len(stall_len), .flush(flush), .hold(hold),
    .ctrl_out(ctrl_out_s), .valid_out(valid_out_s),
    .upstream_hold(upstream_hold_s), .bubble_cnt(bubble_cnt_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive inputs, check the combinational upstream_hold,
  // then pop the expected registered outputs after the edge.
  task automatic cyc(input logic r, input logic [14:0] c, input logic v,
                     input logic sr, input logic [2:0] sl, input logic fl,
                     input logic hd, input logic exp_uh,
                     input logic [14:0] exp_c, input logic exp_v,
                     input logic add_bub);
    exp_t e;
    rst = r; ctrl_in = c; valid_in = v; stall_req = sr;
    stall_len = sl; flush = fl; hold = hd;
    if (r) bubbles = 0;
    else if (add_bub) bubbles++;
    e.ctrl = exp_c; e.valid = exp_v; e.cnt = bubbles;
    e.sat = (bubbles > 15) ? 15 : bubbles;
    exp_q.push_back(e);
    #1;
    chk("upstream_hold", 32'(upstream_hold), 32'(exp_uh));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    $display("step t=%0t ctrl_out=%h valid_out=%b bubble_cnt=%0d sat_cnt=%0d",
             $time, ctrl_out, valid_out, bubble_cnt, bubble_cnt_s);
    chk("ctrl_out", 32'(ctrl_out), 32'(e.ctrl));
    chk("valid_out", 32'(valid_out), 32'(e.valid));
    chk("bubble_cnt", 32'(bubble_cnt), 32'(e.cnt));
    chk("bubble_cnt_sat", 32'(bubble_cnt_s), 32'(e.sat));
  endtask

  initial begin
    rst = 1'b1; ctrl_in = '0; valid_in = 1'b0; stall_req = 1'b0;
    stall_len = '0; flush = 1'b0; hold = 1'b0;

    // reset, 2 cycles
    cyc(1, 15'h4A21, 1, 0, 0, 0, 0, 0, 15'h0000, 0, 0);
    cyc(1, 15'h4A21, 1, 0, 0, 0, 0, 0, 15'h0000, 0, 0);

    // pass-through
    repeat (3) cyc(0, 15'h4A21, 1, 0, 0, 0, 0, 0, 15'h4A21, 1, 0);
    cyc(0, 15'h0F0F, 0, 0, 0, 0, 0, 0, 15'h0F0F, 0, 0);
    // stall_len=0 is no stall
    cyc(0, 15'h2B3C, 1, 1, 0, 0, 0, 0, 15'h2B3C, 1, 0);

    // load-use, single bubble
    cyc(0, 15'h1234, 1, 1, 1, 0, 0, 1, 15'h0000, 0, 1);
    cyc(0, 15'h1234, 1, 0, 0, 0, 0, 0, 15'h1234, 1, 0);

    // three bubbles, re-request during STALL ignored
    cyc(0, 15'h5555, 1, 1, 3, 0, 0, 1, 15'h0000, 0, 1);
    cyc(0, 15'h5555, 1, 1, 7, 0, 0, 1, 15'h0000, 0, 1);
    cyc(0, 15'h5555, 1, 1, 7, 0, 0, 1, 15'h0000, 0, 1);
    cyc(0, 15'h5555, 1, 0, 0, 0, 0, 0, 15'h5555, 1, 0);

    // five requested, flush in 2nd STALL cycle aborts after 2 bubbles
    cyc(0, 15'h6666, 1, 1, 5, 0, 0, 1, 15'h0000, 0, 1);
    cyc(0, 15'h6666, 1, 0, 0, 0, 0, 1, 15'h0000, 0, 1);
    cyc(0, 15'h6666, 1, 1, 3, 1, 0, 0, 15'h0000, 0, 0);
    cyc(0, 15'h7777, 1, 0, 0, 0, 0, 0, 15'h7777, 1, 0);

    // two bubbles with a 4-cycle hold in the middle
    cyc(0, 15'h1111, 1, 1, 2, 0, 0, 1, 15'h0000, 0, 1);
    repeat (4) cyc(0, 15'h1111, 1, 0, 0, 0, 1, 1, 15'h0000, 0, 0);
    cyc(0, 15'h1111, 1, 0, 0, 0, 0, 1, 15'h0000, 0, 1);
    cyc(0, 15'h1111, 1, 0, 0, 0, 0, 0, 15'h1111, 1, 0);

    // hold in RUN freezes; flush beats hold
    cyc(0, 15'h2222, 1, 0, 0, 0, 1, 1, 15'h1111, 1, 0);
    cyc(0, 15'h2222, 1, 0, 0, 0, 0, 0, 15'h2222, 1, 0);
    cyc(0, 15'h3333, 1, 1, 2, 1, 1, 1, 15'h0000, 0, 0);
    cyc(0, 15'h3333, 1, 0, 0, 0, 0, 0, 15'h3333, 1, 0);

    // reset mid-STALL
    cyc(0, 15'h4444, 1, 1, 4, 0, 0, 1, 15'h0000, 0, 1);
    cyc(0, 15'h4444, 1, 0, 0, 0, 0, 1, 15'h0000, 0, 1);
    cyc(1, 15'h4444, 1, 0, 0, 0, 0, 1, 15'h0000, 0, 0);
    cyc(0, 15'h4444, 1, 0, 0, 0, 0, 0, 15'h4444, 1, 0);

    // 20 back-to-back single bubbles; narrow counter stops at 15
    for (int i = 0; i < 20; i++)
      cyc(0, 15'(i + 1), 1, 1, 1, 0, 0, 1, 15'h0000, 0, 1);
    cyc(0, 15'h0ABC, 1, 0, 0, 0, 0, 0, 15'h0ABC, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
